pe_array_v2: RTL and testbench

- Second-generation processing-element array: ROW x COL MAC PEs fed from global-buffer lanes through a per-PE lane-select field.
- Lane-select width is parametrised; the fixed 32:1 lane select is gone.
- New in this generation:
  - ping-pong activation/weight register files, so the next tile loads while the current one computes;
  - a run-length MAC sequencer;
  - optional saturating accumulation;
  - a valid/ready drain port that streams psums out one row per beat.
- Sits between the actv/wgt global buffers and the psum write-back path.

---
 rtl/pe_array_v2.sv | 211 +++++++++++++++++++++
 tb/tb_pe_array_v2.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_v2.sv
// pe_array_v2: ROW x COL signed MAC array with ping-pong actv/wgt register
// files, a run-length MAC sequencer, optional saturating accumulation and a
// valid/ready drain port that streams one row of psums per beat.
module pe_array_v2 #(
  parameter int ROW                = 4,
  parameter int COL                = 4,
  parameter int IN_BITWIDTH        = 8,
  parameter int OUT_BITWIDTH       = 24,
  parameter int GBF_DATA_BITWIDTH  = 256,
  parameter int LANE_SEL_BITWIDTH  = 5,
  parameter int RF_ADDR_BITWIDTH   = 2,
  parameter int RF_DEPTH           = 4,
  parameter int PSUM_ADDR_BITWIDTH = 2,
  parameter int PSUM_DEPTH         = 4,
  parameter int SATURATE           = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [ROW*COL-1:0]                     actv_we,
  input  logic [RF_ADDR_BITWIDTH-1:0]            actv_w_addr,
  input  logic [GBF_DATA_BITWIDTH-1:0]           actv_data,
  input  logic [LANE_SEL_BITWIDTH*ROW*COL-1:0]   actv_lane_sel,
  input  logic [ROW*COL-1:0]                     wgt_we,
  input  logic [RF_ADDR_BITWIDTH-1:0]            wgt_w_addr,
  input  logic [GBF_DATA_BITWIDTH-1:0]           wgt_data,
  input  logic [LANE_SEL_BITWIDTH*ROW*COL-1:0]   wgt_lane_sel,
  input  logic                                   bank_swap,
  input  logic                                   mac_start,
  input  logic [RF_ADDR_BITWIDTH-1:0]            mac_len,
  input  logic [PSUM_ADDR_BITWIDTH-1:0]          psum_addr,
  input  logic                                   acc_clear,
  input  logic                                   drain_start,
  input  logic [PSUM_ADDR_BITWIDTH-1:0]          drain_addr,
  input  logic                                   out_ready,
  output logic                                   out_valid,
  output logic [OUT_BITWIDTH*COL-1:0]            out_data,
  output logic [$clog2(ROW)-1:0]                 out_row,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   swap_err
);
  // state     | meaning
  // S_IDLE    | waiting for mac_start / drain_start; bank_swap accepted
  // S_COMPUTE | one MAC step per cycle over k = 0 .. len-1
  // S_DRAIN   | streaming psum rows 0 .. ROW-1 with valid/ready
  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DRAIN} state_t;

  localparam int LANES      = GBF_DATA_BITWIDTH / IN_BITWIDTH;
  localparam int LANE_IDX_W = $clog2(LANES);
  localparam int ROW_W      = $clog2(ROW);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [RF_ADDR_BITWIDTH-1:0] RF_ONE = RF_ADDR_BITWIDTH'(1);

  state_t state_q, state_d;
  logic rd_bank_q, rd_bank_d, swap_err_q, swap_err_d, clr_q, clr_d;
  logic [RF_ADDR_BITWIDTH-1:0] k_q, k_d, len_q, len_d;
  logic [PSUM_ADDR_BITWIDTH-1:0] paddr_q, paddr_d, daddr_q, daddr_d;
  logic [ROW_W-1:0] r_q, r_d;
  logic k_last, r_last;
  logic [OUT_BITWIDTH-1:0] pe_out [ROW*COL];

  // Out-of-range lane selects load 0 rather than aliasing another lane.
  function automatic logic [IN_BITWIDTH-1:0] lane_pick(
    input logic [GBF_DATA_BITWIDTH-1:0] word,
    input logic [LANE_SEL_BITWIDTH-1:0] sel);
    logic [LANES-1:0][IN_BITWIDTH-1:0] lanes_v;
    logic [31:0] idx;
    lanes_v = word;
    idx = 32'(sel);
    lane_pick = '0;
    if (idx < 32'(LANES)) lane_pick = lanes_v[idx[LANE_IDX_W-1:0]];
  endfunction

  // Accumulate in OUT_BITWIDTH+1 bits so overflow is visible in the top two bits.
  function automatic logic [OUT_BITWIDTH-1:0] mac_step(
    input logic [IN_BITWIDTH-1:0] a,
    input logic [IN_BITWIDTH-1:0] w,
    input logic [OUT_BITWIDTH-1:0] acc,
    input logic first);
    logic signed [2*IN_BITWIDTH-1:0] a_x, w_x, prod;
    logic signed [OUT_BITWIDTH:0] prod_x, acc_x, sum;
    a_x = {{IN_BITWIDTH{a[IN_BITWIDTH-1]}}, a};
    w_x = {{IN_BITWIDTH{w[IN_BITWIDTH-1]}}, w};
    prod = a_x * w_x;
    prod_x = {{(OUT_BITWIDTH+1-2*IN_BITWIDTH){prod[2*IN_BITWIDTH-1]}}, prod};
    acc_x = {acc[OUT_BITWIDTH-1], acc};
    sum = first ? prod_x : acc_x + prod_x;
    if (SATURATE != 0 && sum[OUT_BITWIDTH] != sum[OUT_BITWIDTH-1])
      mac_step = sum[OUT_BITWIDTH] ? {1'b1, {(OUT_BITWIDTH-1){1'b0}}}
                                   : {1'b0, {(OUT_BITWIDTH-1){1'b1}}};
    else
      mac_step = sum[OUT_BITWIDTH-1:0];
  endfunction

  // len_q == 0 encodes RF_DEPTH: len-1 wraps to the last address.
  assign k_last = (k_q == len_q - RF_ONE);
  assign r_last = (r_q == ROW_LAST);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; mac_start has priority over drain_start
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mac_start)        state_d = S_COMPUTE;
        else if (drain_start) state_d = S_DRAIN;
      end
      S_COMPUTE: if (k_last) state_d = S_IDLE;
      S_DRAIN:   if (out_ready && r_last) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_COMPUTE) && k_last;
    out_valid = (state_q == S_DRAIN);
    out_last  = out_valid && r_last;
    out_row   = out_valid ? r_q : '0;
  end

  // Sequencer bookkeeping: bank select, swap error, run/drain counters
  always_comb begin
    rd_bank_d  = rd_bank_q;
    swap_err_d = swap_err_q;
    k_d = k_q; len_d = len_q; paddr_d = paddr_q; clr_d = clr_q;
    r_d = r_q; daddr_d = daddr_q;
    if (bank_swap) begin
      if (state_q == S_IDLE) rd_bank_d  = ~rd_bank_q;
      else                   swap_err_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (mac_start) begin
          len_d = mac_len; paddr_d = psum_addr; clr_d = acc_clear; k_d = '0;
        end else if (drain_start) begin
          r_d = '0; daddr_d = drain_addr;
        end
      end
      S_COMPUTE: k_d = k_q + RF_ONE;
      S_DRAIN:   if (out_ready) r_d = r_q + ROW_ONE;
      default: ;
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_bank_q <= 1'b0; swap_err_q <= 1'b0; clr_q <= 1'b0;
      k_q <= '0; len_q <= '0; paddr_q <= '0; r_q <= '0; daddr_q <= '0;
    end else begin
      rd_bank_q <= rd_bank_d; swap_err_q <= swap_err_d; clr_q <= clr_d;
      k_q <= k_d; len_q <= len_d; paddr_q <= paddr_d; r_q <= r_d; daddr_q <= daddr_d;
    end
  end

  assign swap_err = swap_err_q;

  for (genvar p = 0; p < ROW*COL; p++) begin : g_pe
    logic [IN_BITWIDTH-1:0] actv_q [2][RF_DEPTH], actv_d [2][RF_DEPTH];
    logic [IN_BITWIDTH-1:0] wgt_q  [2][RF_DEPTH], wgt_d  [2][RF_DEPTH];
    logic [OUT_BITWIDTH-1:0] psum_q [PSUM_DEPTH], psum_d [PSUM_DEPTH];

    // Loads go to the idle bank; MAC reads the compute bank
    always_comb begin
      actv_d = actv_q;
      wgt_d  = wgt_q;
      psum_d = psum_q;
      if (actv_we[p])
        actv_d[~rd_bank_q][actv_w_addr] =
          lane_pick(actv_data, actv_lane_sel[LANE_SEL_BITWIDTH*p +: LANE_SEL_BITWIDTH]);
      if (wgt_we[p])
        wgt_d[~rd_bank_q][wgt_w_addr] =
          lane_pick(wgt_data, wgt_lane_sel[LANE_SEL_BITWIDTH*p +: LANE_SEL_BITWIDTH]);
      if (state_q == S_COMPUTE)
        psum_d[paddr_q] = mac_step(actv_q[rd_bank_q][k_q], wgt_q[rd_bank_q][k_q],
                                   psum_q[paddr_q], clr_q && (k_q == '0));
    end

    // PE storage
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        actv_q <= '{default: '0};
        wgt_q  <= '{default: '0};
        psum_q <= '{default: '0};
      end else begin
        actv_q <= actv_d;
        wgt_q  <= wgt_d;
        psum_q <= psum_d;
      end
    end

    assign pe_out[p] = psum_q[daddr_q];
  end

  for (genvar c = 0; c < COL; c++) begin : g_col
    logic [ROW-1:0][OUT_BITWIDTH-1:0] col_v;
    for (genvar r = 0; r < ROW; r++) begin : g_row
      assign col_v[r] = pe_out[r*COL + c];
    end
    assign out_data[OUT_BITWIDTH*c +: OUT_BITWIDTH] = out_valid ? col_v[r_q] : '0;
  end
endmodule

// File: tb/tb_pe_array_v2.sv
// Directed bench for pe_array_v2: a default instance plus two 16-bit
// instances (saturating and wrapping) driven by the same stimulus.
module tb_pe_array_v2;
  logic clk = 1'b0;
  logic reset;
  logic [15:0]  actv_we, wgt_we;
  logic [1:0]   actv_w_addr, wgt_w_addr;
  logic [255:0] actv_data, wgt_data;
  logic [79:0]  actv_lane_sel, wgt_lane_sel;
  logic bank_swap, mac_start, acc_clear, drain_start, out_ready;
  logic [1:0] mac_len, psum_addr, drain_addr;

  logic out_valid, out_last, busy, done, swap_err;
  logic [95:0] out_data;
  logic [1:0]  out_row;
  logic s_out_valid, s_out_last, s_busy, s_done, s_swap_err;
  logic [63:0] s_out_data;
  logic [1:0]  s_out_row;
  logic w_out_valid, w_out_last, w_busy, w_done, w_swap_err;
  logic [63:0] w_out_data;
  logic [1:0]  w_out_row;

  int total = 0;
  int bad = 0;
  logic [95:0] drn_m [4];
  logic [63:0] drn_s [4];
  logic [63:0] drn_w [4];
  int drn_beats;

  always #5 clk = ~clk;

  pe_array_v2 dut (
    .clk(clk), .reset(reset),
    .actv_we(actv_we), .actv_w_addr(actv_w_addr), .actv_data(actv_data), .actv_lane_sel(actv_lane_sel),
    .wgt_we(wgt_we), .wgt_w_addr(wgt_w_addr), .wgt_data(wgt_data), .wgt_lane_sel(wgt_lane_sel),
    .bank_swap(bank_swap), .mac_start(mac_start), .mac_len(mac_len), .psum_addr(psum_addr),
    .acc_clear(acc_clear), .drain_start(drain_start), .drain_addr(drain_addr), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_row(out_row), .out_last(out_last),
    .busy(busy), .done(done), .swap_err(swap_err));

  pe_array_v2 #(.OUT_BITWIDTH(16), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset),
    .actv_we(actv_we), .actv_w_addr(actv_w_addr), .actv_data(actv_data), .actv_lane_sel(actv_lane_sel),
    .wgt_we(wgt_we), .wgt_w_addr(wgt_w_addr), .wgt_data(wgt_data), .wgt_lane_sel(wgt_lane_sel),
    .bank_swap(bank_swap), .mac_start(mac_start), .mac_len(mac_len), .psum_addr(psum_addr),
    .acc_clear(acc_clear), .drain_start(drain_start), .drain_addr(drain_addr), .out_ready(out_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_row(s_out_row), .out_last(s_out_last),
    .busy(s_busy), .done(s_done), .swap_err(s_swap_err));

  pe_array_v2 #(.OUT_BITWIDTH(16), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset),
    .actv_we(actv_we), .actv_w_addr(actv_w_addr), .actv_data(actv_data), .actv_lane_sel(actv_lane_sel),
    .wgt_we(wgt_we), .wgt_w_addr(wgt_w_addr), .wgt_data(wgt_data), .wgt_lane_sel(wgt_lane_sel),
    .bank_swap(bank_swap), .mac_start(mac_start), .mac_len(mac_len), .psum_addr(psum_addr),
    .acc_clear(acc_clear), .drain_start(drain_start), .drain_addr(drain_addr), .out_ready(out_ready),
    .out_valid(w_out_valid), .out_data(w_out_data), .out_row(w_out_row), .out_last(w_out_last),
    .busy(w_busy), .done(w_done), .swap_err(w_swap_err));

  // One load cycle: lane 0 of each word, all lane selects 0.
  task automatic load_entry(input logic [15:0] awe, input logic [15:0] wwe,
                            input logic [1:0] addr, input logic [7:0] av, input logic [7:0] wv);
    actv_lane_sel = '0; wgt_lane_sel = '0;
    actv_data = '0; wgt_data = '0;
    actv_data[7:0] = av; wgt_data[7:0] = wv;
    actv_we = awe; wgt_we = wwe;
    actv_w_addr = addr; wgt_w_addr = addr;
    @(negedge clk);
    actv_we = '0; wgt_we = '0;
  endtask

  task automatic do_swap();
    bank_swap = 1'b1;
    @(negedge clk);
    bank_swap = 1'b0;
  endtask

  task automatic run_mac(input logic [1:0] len, input logic [1:0] paddr, input logic clr);
    int n;
    mac_start = 1'b1; mac_len = len; psum_addr = paddr; acc_clear = clr;
    @(negedge clk);
    mac_start = 1'b0;
    n = 0;
    while (busy && n < 10) begin @(negedge clk); n++; end
    if (busy) begin
      total++; bad++;
      $display("FAIL run_mac_timeout busy still high after %0d cycles", n);
    end
  endtask

  task automatic drain_all(input logic [1:0] addr);
    int n;
    for (int r = 0; r < 4; r++) begin drn_m[r] = 'x; drn_s[r] = 'x; drn_w[r] = 'x; end
    out_ready = 1'b1; drain_start = 1'b1; drain_addr = addr;
    @(negedge clk);
    drain_start = 1'b0;
    n = 0;
    while (out_valid && n < 8) begin
      drn_m[out_row] = out_data; drn_s[out_row] = s_out_data; drn_w[out_row] = w_out_data;
      @(negedge clk);
      n++;
    end
    drn_beats = n;
    if (out_valid) begin
      total++; bad++;
      $display("FAIL drain_timeout out_valid still high after %0d beats", n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    actv_we = '0; wgt_we = '0; actv_w_addr = '0; wgt_w_addr = '0;
    actv_data = '0; wgt_data = '0; actv_lane_sel = '0; wgt_lane_sel = '0;
    bank_swap = 0; mac_start = 0; mac_len = '0; psum_addr = '0; acc_clear = 0;
    drain_start = 0; drain_addr = '0; out_ready = 0;
    repeat (3) @(negedge clk);
    total++; if ({out_valid, busy, done, swap_err, out_last} !== 5'b0) begin bad++;
      $display("FAIL reset_ctrl got=%b exp=00000", {out_valid, busy, done, swap_err, out_last}); end
    total++; if (out_data !== 96'd0 || out_row !== 2'd0) begin bad++;
      $display("FAIL reset_data got=%h/%0d exp=0/0", out_data, out_row); end
    reset = 1'b1;
    @(negedge clk);
    drain_all(2'd0);
    total++; if (drn_beats !== 4) begin bad++;
      $display("FAIL reset_drain_beats got=%0d exp=4", drn_beats); end
    for (int r = 0; r < 4; r++) begin
      total++; if (drn_m[r] !== 96'd0) begin bad++;
        $display("FAIL reset_psum row%0d got=%h exp=0", r, drn_m[r]); end
    end
  endtask

  task automatic test_lane_select();
    logic [95:0] e;
    logic [63:0] es;
    // PE(1,2) = index 6 picks lane 7 (0xF3); lane 0 holds a decoy value.
    actv_lane_sel = '0; actv_lane_sel[30 +: 5] = 5'd7;
    actv_data = '0; actv_data[56 +: 8] = 8'hF3; actv_data[7:0] = 8'h55;
    actv_we = 16'h0040; actv_w_addr = 2'd1;
    @(negedge clk);
    actv_we = '0;
    for (int a = 0; a < 4; a++) load_entry(16'h0000, 16'hFFFF, 2'(a), 8'h00, 8'h01);
    do_swap();
    run_mac(2'd2, 2'd0, 1'b1);
    drain_all(2'd0);
    total++; if (drn_beats !== 4) begin bad++;
      $display("FAIL lane_beats got=%0d exp=4", drn_beats); end
    for (int r = 0; r < 4; r++) begin
      e = '0;
      if (r == 1) e[48 +: 24] = 24'hFFFFF3;
      total++; if (drn_m[r] !== e) begin bad++;
        $display("FAIL lane_row%0d got=%h exp=%h", r, drn_m[r], e); end
    end
    es = '0; es[32 +: 16] = 16'hFFF3;
    total++; if (drn_s[1] !== es) begin bad++;
      $display("FAIL lane_row1_16b got=%h exp=%h", drn_s[1], es); end
  endtask

  task automatic test_accumulate();
    for (int a = 0; a < 4; a++) load_entry(16'h0001, 16'h0001, 2'(a), 8'(a + 1), 8'(a + 5));
    do_swap();
    mac_start = 1'b1; mac_len = 2'd0; psum_addr = 2'd1; acc_clear = 1'b1;
    @(negedge clk);
    mac_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (busy !== 1'b1 || done !== (i == 3)) begin bad++;
        $display("FAIL acc_timing cycle%0d got busy=%b done=%b exp busy=1 done=%b", i, busy, done, i == 3); end
      @(negedge clk);
    end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++;
      $display("FAIL acc_end got busy=%b done=%b exp 0 0", busy, done); end
    drain_all(2'd1);
    total++; if (drn_m[0] !== 96'd70) begin bad++;
      $display("FAIL acc_first got=%h exp=%h", drn_m[0], 96'd70); end
    run_mac(2'd0, 2'd1, 1'b0);
    drain_all(2'd1);
    total++; if (drn_m[0] !== 96'd140) begin bad++;
      $display("FAIL acc_second got=%h exp=%h", drn_m[0], 96'd140); end
  endtask

  task automatic test_saturate();
    for (int a = 0; a < 4; a++) load_entry(16'hFFFF, 16'hFFFF, 2'(a), 8'd127, 8'd127);
    do_swap();
    run_mac(2'd0, 2'd2, 1'b1);
    drain_all(2'd2);
    total++; if (drn_s[0][15:0] !== 16'h7FFF) begin bad++;
      $display("FAIL sat_pos got=%h exp=7fff", drn_s[0][15:0]); end
    total++; if (drn_s[3][63:48] !== 16'h7FFF) begin bad++;
      $display("FAIL sat_pos_r3c3 got=%h exp=7fff", drn_s[3][63:48]); end
    total++; if (drn_w[0][15:0] !== 16'hFC04) begin bad++;
      $display("FAIL wrap_pos got=%h exp=fc04", drn_w[0][15:0]); end
    total++; if (drn_m[0][23:0] !== 24'h00FC04) begin bad++;
      $display("FAIL wide_pos got=%h exp=00fc04", drn_m[0][23:0]); end
    for (int a = 0; a < 4; a++) load_entry(16'hFFFF, 16'hFFFF, 2'(a), 8'h80, 8'd127);
    do_swap();
    run_mac(2'd0, 2'd2, 1'b1);
    drain_all(2'd2);
    total++; if (drn_s[0][15:0] !== 16'h8000) begin bad++;
      $display("FAIL sat_neg got=%h exp=8000", drn_s[0][15:0]); end
    total++; if (drn_w[0][15:0] !== 16'h0200) begin bad++;
      $display("FAIL wrap_neg got=%h exp=0200", drn_w[0][15:0]); end
    total++; if (drn_m[2][47:24] !== 24'hFF0200) begin bad++;
      $display("FAIL wide_neg got=%h exp=ff0200", drn_m[2][47:24]); end
  endtask

  task automatic test_drain_stall();
    logic pat [6];
    logic [95:0] e;
    int er;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    drain_start = 1'b1; drain_addr = 2'd0; out_ready = 1'b0;
    @(negedge clk);
    drain_start = 1'b0;
    er = 0;
    for (int i = 0; i < 6; i++) begin
      out_ready = pat[i];
      e = '0;
      if (er == 1) e[48 +: 24] = 24'hFFFFF3;
      total++; if (out_valid !== 1'b1 || out_row !== 2'(er)) begin bad++;
        $display("FAIL stall_beat%0d got valid=%b row=%0d exp valid=1 row=%0d", i, out_valid, out_row, er); end
      total++; if (out_data !== e) begin bad++;
        $display("FAIL stall_data%0d got=%h exp=%h", i, out_data, e); end
      total++; if (out_last !== (er == 3)) begin bad++;
        $display("FAIL stall_last%0d got=%b exp=%b", i, out_last, er == 3); end
      @(negedge clk);
      if (pat[i]) er++;
    end
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL stall_end got valid=%b busy=%b exp 0 0", out_valid, busy); end
    out_ready = 1'b1;
  endtask

  task automatic test_swap_err();
    int dones;
    logic seen;
    mac_start = 1'b1; mac_len = 2'd0; psum_addr = 2'd3; acc_clear = 1'b1;
    @(negedge clk);
    mac_start = 1'b0; bank_swap = 1'b1;
    @(negedge clk);
    bank_swap = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (swap_err !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL swap_err got err=%b busy=%b exp 1 0", swap_err, busy); end
    drain_all(2'd3);
    total++; if (drn_m[0][23:0] !== 24'hFF0200) begin bad++;
      $display("FAIL swap_run got=%h exp=ff0200", drn_m[0][23:0]); end
    run_mac(2'd1, 2'd3, 1'b1);
    drain_all(2'd3);
    total++; if (drn_m[0][23:0] !== 24'hFFC080) begin bad++;
      $display("FAIL swap_bank_kept got=%h exp=ffc080", drn_m[0][23:0]); end
    // Both starts together: compute only, never a drain beat.
    mac_start = 1'b1; drain_start = 1'b1; mac_len = 2'd2; psum_addr = 2'd3; acc_clear = 1'b0;
    @(negedge clk);
    mac_start = 1'b0; drain_start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++;
      $display("FAIL both_start_busy got=%b exp=1", busy); end
    seen = 1'b0; dones = 0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | out_valid;
      if (done) dones++;
      @(negedge clk);
    end
    total++; if (seen !== 1'b0 || dones !== 1) begin bad++;
      $display("FAIL both_start got valid_seen=%b dones=%0d exp 0 1", seen, dones); end
    total++; if (swap_err !== 1'b1) begin bad++;
      $display("FAIL swap_err_sticky got=%b exp=1", swap_err); end
  endtask

  task automatic test_reset_mid_drain();
    out_ready = 1'b1; drain_start = 1'b1; drain_addr = 2'd0;
    @(negedge clk);
    drain_start = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_row !== 2'd1) begin bad++;
      $display("FAIL mid_drain_pre got valid=%b row=%0d exp 1 1", out_valid, out_row); end
    out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    total++; if ({out_valid, busy, done, swap_err} !== 4'b0 || out_data !== 96'd0) begin bad++;
      $display("FAIL mid_drain_reset got=%b data=%h exp=0000 data=0", {out_valid, busy, done, swap_err}, out_data); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      drain_all(2'(a));
      total++; if (drn_beats !== 4) begin bad++;
        $display("FAIL post_reset_beats addr%0d got=%0d exp=4", a, drn_beats); end
      for (int r = 0; r < 4; r++) begin
        total++; if (drn_m[r] !== 96'd0 || drn_s[r] !== 64'd0) begin bad++;
          $display("FAIL post_reset_psum addr%0d row%0d got=%h/%h exp=0", a, r, drn_m[r], drn_s[r]); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lane_select();
    test_accumulate();
    test_saturate();
    test_drain_stall();
    test_swap_err();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
